// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall bundle between the pipeline datapath and the stall controller.
// Signal names carry the controller's point of view (_i into the controller,
// _o out of it). CNT_W sizes the performance counter outputs and must match
// the CNT_W of the attached pipe_stall_ctrl.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);

  // hazard sources seen by the controller
  logic [4:0]       ID_rs1_i;
  logic [4:0]       ID_rs2_i;
  logic [4:0]       EX_rd_i;
  logic             EX_MemRead_i;
  logic             ID_branch_taken_i;
  logic             MEM_req_i;
  logic             dcache_stall_i;

  // pipeline controls produced by the controller
  logic             PC_write_o;
  logic             IF_ID_write_o;
  logic             ID_EX_bubble_o;
  logic             IF_ID_flush_o;
  logic             pipe_stall_o;
  logic             timeout_o;

  // performance counters
  logic [CNT_W-1:0] mem_stall_cnt_o;
  logic [CNT_W-1:0] lu_bubble_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // pipeline side: drives hazard sources, consumes controls
  modport master (
    output ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, ID_branch_taken_i,
           MEM_req_i, dcache_stall_i,
    input  PC_write_o, IF_ID_write_o, ID_EX_bubble_o, IF_ID_flush_o,
           pipe_stall_o, timeout_o, mem_stall_cnt_o, lu_bubble_cnt_o,
           flush_cnt_o
  );

  // controller side
  modport slave (
    input  ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, ID_branch_taken_i,
           MEM_req_i, dcache_stall_i,
    output PC_write_o, IF_ID_write_o, ID_EX_bubble_o, IF_ID_flush_o,
           pipe_stall_o, timeout_o, mem_stall_cnt_o, lu_bubble_cnt_o,
           flush_cnt_o
  );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order core.
//   - memory stall (dcache miss) freezes the whole pipe, highest priority
//   - load-use hazard holds PC and IF/ID and bubbles ID/EX
//   - a taken branch in ID flushes IF/ID
// A watchdog flags a dcache wait lasting TIMEOUT consecutive cycles; the
// flag is sticky until reset.
//
// Optional build macro: STALL_PERF_EN
//   defined   -> memory-stall, load-use-bubble and flush counters implemented
//   undefined -> no counter flops, counter outputs tied to zero
//
// State   | meaning
// --------+------------------------------------------------------------
// ST_RUN  | no dcache access outstanding
// ST_WAIT | dcache miss outstanding, stall held until dcache_stall_i drops
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Watchdog is a down-counter: loaded with TIMEOUT, decremented on every
  // stalled cycle, reloaded on any unstalled cycle. Reaching zero is the
  // same event as an up-count reaching TIMEOUT.
  localparam int             WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_TC   = WD_W'(1);

  state_t          state_q;
  state_t          state_d;
  logic            load_use;
  logic            stall;
  logic            pc_write;
  logic            if_id_write;
  logic            id_ex_bubble;
  logic            if_id_flush;
  logic [WD_W-1:0] wd_rem_q;
  logic            timeout_q;

  // Load-use hazard: load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use = bus.EX_MemRead_i && (bus.EX_rd_i != 5'd0) &&
               ((bus.EX_rd_i == bus.ID_rs1_i) || (bus.EX_rd_i == bus.ID_rs2_i));
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (bus.MEM_req_i && bus.dcache_stall_i) state_d = ST_WAIT;
      ST_WAIT: if (!bus.dcache_stall_i)                 state_d = ST_RUN;
      default:                                          state_d = ST_RUN;
    endcase
  end

  // FSM outputs: stall is combinational from dcache_stall_i so the pipe
  // freezes in the same cycle the miss is signalled; reset forces a
  // free-running pipe.
  always_comb begin
    stall        = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst_i) begin
      stall = bus.dcache_stall_i && (bus.MEM_req_i || (state_q == ST_WAIT));
      if (stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else begin
        if_id_flush = bus.ID_branch_taken_i;
      end
    end
  end

  assign bus.pipe_stall_o   = stall;
  assign bus.PC_write_o     = pc_write;
  assign bus.IF_ID_write_o  = if_id_write;
  assign bus.ID_EX_bubble_o = id_ex_bubble;
  assign bus.IF_ID_flush_o  = if_id_flush;

  // Watchdog down-counter and sticky timeout flag; the counter parks at
  // zero while the stall continues.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_rem_q  <= WD_LOAD;
      timeout_q <= 1'b0;
    end else begin
      if (!stall) begin
        wd_rem_q <= WD_LOAD;
      end else if (wd_rem_q != '0) begin
        wd_rem_q <= wd_rem_q - WD_TC;
      end
      if (stall && (wd_rem_q == WD_TC)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_o = timeout_q;

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] mem_stall_cnt_q;
  logic [CNT_W-1:0] lu_bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Free-running event counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_stall_cnt_q <= '0;
      lu_bubble_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      if (stall)        mem_stall_cnt_q <= mem_stall_cnt_q + CNT_W'(1);
      if (id_ex_bubble) lu_bubble_cnt_q <= lu_bubble_cnt_q + CNT_W'(1);
      if (if_id_flush)  flush_cnt_q     <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.mem_stall_cnt_o = mem_stall_cnt_q;
  assign bus.lu_bubble_cnt_o = lu_bubble_cnt_q;
  assign bus.flush_cnt_o     = flush_cnt_q;
`else
  assign bus.mem_stall_cnt_o = {CNT_W{1'b0}};
  assign bus.lu_bubble_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (TIMEOUT = 8). Counter expectations
// collapse to zero when STALL_PERF_EN is not defined.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mq;
    logic       ds;
    logic       pc;
    logic       ifid;
    logic       bub;
    logic       fl;
    logic       st;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  logic [31:0] m_ms, m_lu, m_fl;

  function automatic vec_t mk(int r, int rs1, int rs2, int rd, int mr, int br,
                              int mq, int ds, int pc, int ifid, int bub,
                              int fl, int st);
    vec_t v;
    v.rst = r[0];   v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.mr  = mr[0];  v.br  = br[0];   v.mq  = mq[0];   v.ds = ds[0];
    v.pc  = pc[0];  v.ifid = ifid[0]; v.bub = bub[0]; v.fl = fl[0];
    v.st  = st[0];
    return v;
  endfunction

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  task automatic check_cnt(string name, logic [31:0] act, logic [31:0] model);
    logic [31:0] exp;
`ifdef STALL_PERF_EN
    exp = model;
`else
    exp = 32'd0;
`endif
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(int rs1, int rs2, int rd, int mr, int br, int mq, int ds);
    bus.ID_rs1_i          = 5'(rs1);
    bus.ID_rs2_i          = 5'(rs2);
    bus.EX_rd_i           = 5'(rd);
    bus.EX_MemRead_i      = mr[0];
    bus.ID_branch_taken_i = br[0];
    bus.MEM_req_i         = mq[0];
    bus.dcache_stall_i    = ds[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //              r rs1 rs2 rd mr br mq ds  pc if bu fl st
    vecs[0]  = mk(0, 0,  0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    vecs[1]  = mk(0, 5,  0,  5, 1, 0, 0, 0,  0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 3,  5,  5, 1, 0, 0, 0,  0, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0,  0,  0, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    vecs[4]  = mk(0, 5,  0,  5, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 6,  7,  5, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    vecs[6]  = mk(0, 1,  2,  3, 0, 1, 0, 0,  1, 1, 0, 1, 0);
    vecs[7]  = mk(0, 9,  4,  9, 1, 1, 0, 0,  0, 0, 1, 0, 0);
    vecs[8]  = mk(0, 0,  0,  0, 0, 0, 1, 0,  1, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0,  0,  0, 0, 0, 0, 1,  1, 1, 0, 0, 0);
    vecs[10] = mk(0, 5,  0,  5, 1, 1, 1, 1,  0, 0, 0, 0, 1);
    vecs[11] = mk(0, 0,  0,  0, 0, 1, 0, 0,  1, 1, 0, 1, 0);
    vecs[12] = mk(0, 0,  0,  0, 0, 0, 0, 1,  1, 1, 0, 0, 0);
    vecs[13] = mk(0, 31, 0, 31, 1, 0, 0, 0,  0, 0, 1, 0, 0);
    vecs[14] = mk(1, 5,  0,  5, 1, 1, 1, 1,  1, 1, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    @(negedge clk);
    check1("reset_stall", bus.pipe_stall_o, 1'b0);
    check1("reset_timeout", bus.timeout_o, 1'b0);
    check_cnt("reset_ms_cnt", bus.mem_stall_cnt_o, 32'd0);
    check_cnt("reset_lu_cnt", bus.lu_bubble_cnt_o, 32'd0);
    check_cnt("reset_fl_cnt", bus.flush_cnt_o, 32'd0);
    tick();

    // table vectors
    m_ms = 0; m_lu = 0; m_fl = 0;
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].br,
            vecs[i].mq, vecs[i].ds);
      @(negedge clk);
      check1($sformatf("v%0d_pc_write", i), bus.PC_write_o, vecs[i].pc);
      check1($sformatf("v%0d_if_id_write", i), bus.IF_ID_write_o, vecs[i].ifid);
      check1($sformatf("v%0d_bubble", i), bus.ID_EX_bubble_o, vecs[i].bub);
      check1($sformatf("v%0d_flush", i), bus.IF_ID_flush_o, vecs[i].fl);
      check1($sformatf("v%0d_stall", i), bus.pipe_stall_o, vecs[i].st);
      tick();
      if (vecs[i].rst) begin
        m_ms = 0; m_lu = 0; m_fl = 0;
      end else begin
        m_ms = m_ms + 32'(vecs[i].st);
        m_lu = m_lu + 32'(vecs[i].bub);
        m_fl = m_fl + 32'(vecs[i].fl);
      end
      check_cnt($sformatf("v%0d_ms_cnt", i), bus.mem_stall_cnt_o, m_ms);
      check_cnt($sformatf("v%0d_lu_cnt", i), bus.lu_bubble_cnt_o, m_lu);
      check_cnt($sformatf("v%0d_fl_cnt", i), bus.flush_cnt_o, m_fl);
      check1($sformatf("v%0d_timeout", i), bus.timeout_o, 1'b0);
    end
    rst = 1'b0;

    // load-use bubble, then rd = x0 gives none
    do_reset();
    drive(5, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    check1("lu_bubble", bus.ID_EX_bubble_o, 1'b1);
    check1("lu_pc_write", bus.PC_write_o, 1'b0);
    check1("lu_if_id_write", bus.IF_ID_write_o, 1'b0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check1("lu_x0_bubble", bus.ID_EX_bubble_o, 1'b0);
    check1("lu_x0_pc_write", bus.PC_write_o, 1'b1);
    tick();
    check_cnt("lu_cnt_after", bus.lu_bubble_cnt_o, 32'd1);

    // branch suppressed by load-use, then taken on the next cycle
    do_reset();
    drive(5, 0, 5, 1, 1, 0, 0);
    @(negedge clk);
    check1("br_lu_flush", bus.IF_ID_flush_o, 1'b0);
    check1("br_lu_bubble", bus.ID_EX_bubble_o, 1'b1);
    tick();
    drive(5, 0, 5, 0, 1, 0, 0);
    @(negedge clk);
    check1("br_flush", bus.IF_ID_flush_o, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("br_fl_cnt", bus.flush_cnt_o, 32'd1);
    check_cnt("br_lu_cnt", bus.lu_bubble_cnt_o, 32'd1);

    // ten-cycle miss
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check1($sformatf("miss_stall_c%0d", c + 1), bus.pipe_stall_o, 1'b1);
      check1($sformatf("miss_pc_c%0d", c + 1), bus.PC_write_o, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, c[0], 1);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check1("miss_end_stall", bus.pipe_stall_o, 1'b0);
    check1("miss_end_pc", bus.PC_write_o, 1'b1);
    check1("miss_end_flush", bus.IF_ID_flush_o, 1'b1);
    tick();
    check_cnt("miss_ms_cnt", bus.mem_stall_cnt_o, 32'd10);
    check1("miss_timeout", bus.timeout_o, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check1("miss_back_to_run", bus.pipe_stall_o, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);

    // watchdog restarts after an unstalled cycle
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 7; c++) tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 7; c++) tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check1("wd_restart_timeout", bus.timeout_o, 1'b0);
    check_cnt("wd_restart_ms_cnt", bus.mem_stall_cnt_o, 32'd14);

    // timeout rises at the 8th stall edge and is sticky
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      drive(0, 0, 0, 0, 0, 0, 1);
      check1($sformatf("wd_timeout_edge%0d", k), bus.timeout_o, k >= 8);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check1($sformatf("wd_sticky%0d", k), bus.timeout_o, 1'b1);
    end
    do_reset();
    check1("wd_cleared_by_reset", bus.timeout_o, 1'b0);

    // reset in cycle 3 of a WAIT sequence
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    rst = 1'b1;
    drive(5, 0, 5, 1, 1, 0, 1);
    @(negedge clk);
    check1("rst_wait_stall", bus.pipe_stall_o, 1'b0);
    check1("rst_wait_pc", bus.PC_write_o, 1'b1);
    check1("rst_wait_ifid", bus.IF_ID_write_o, 1'b1);
    check1("rst_wait_bubble", bus.ID_EX_bubble_o, 1'b0);
    check1("rst_wait_flush", bus.IF_ID_flush_o, 1'b0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cnt("rst_wait_ms_cnt", bus.mem_stall_cnt_o, 32'd0);
    check1("rst_wait_timeout", bus.timeout_o, 1'b0);
    @(negedge clk);
    check1("rst_wait_state_run", bus.pipe_stall_o, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 3; c++) tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_cnt("rst_wait_new_miss_cnt", bus.mem_stall_cnt_o, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024: number of consecutive dcache-wait cycles after which the watchdog fires.
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 ID_rs1_i  input  5  rs1 of the instruction in ID.
REQ-006 ID_rs2_i  input  5  rs2 of the instruction in ID.
REQ-007 EX_rd_i  input  5  rd of the instruction in EX.
REQ-008 EX_MemRead_i  input  1  the instruction in EX is a load.
REQ-009 ID_branch_taken_i  input  1  branch in ID resolved taken.
REQ-010 MEM_req_i  input  1  the instruction in MEM accesses the dcache.
REQ-011 dcache_stall_i  input  1  dcache is not ready; held high until the access completes.
REQ-012 PC_write_o  output  1  PC update enable.
REQ-013 IF_ID_write_o  output  1  IF/ID register write enable.
REQ-014 ID_EX_bubble_o  output  1  inject a NOP into ID/EX.
REQ-015 IF_ID_flush_o  output  1  clear IF/ID.
REQ-016 pipe_stall_o  output  1  freeze all pipeline registers and the PC.
REQ-017 timeout_o  output  1  sticky watchdog flag.
REQ-018 mem_stall_cnt_o, lu_bubble_cnt_o, flush_cnt_o  output  CNT_W each  performance counters.

Function
REQ-019 load_use = EX_MemRead_i & (EX_rd_i != 0) & ((EX_rd_i == ID_rs1_i) | (EX_rd_i == ID_rs2_i)), combinational.
REQ-020 FSM states RUN and WAIT: RUN->WAIT when MEM_req_i & dcache_stall_i; WAIT->RUN when dcache_stall_i == 0; otherwise hold.
REQ-021 pipe_stall_o = dcache_stall_i & (MEM_req_i | state == WAIT), combinational, with zero-cycle latency from dcache_stall_i.
REQ-022 Priority: memory stall > load-use > branch flush.
REQ-023 When pipe_stall_o = 1: PC_write_o = 0, IF_ID_write_o = 0, ID_EX_bubble_o = 0, IF_ID_flush_o = 0.
REQ-024 Else if load_use: PC_write_o = 0, IF_ID_write_o = 0, ID_EX_bubble_o = 1, IF_ID_flush_o = 0 (branch ignored this cycle).
REQ-025 Else: PC_write_o = 1, IF_ID_write_o = 1, ID_EX_bubble_o = 0, IF_ID_flush_o = ID_branch_taken_i.
REQ-026 The cycle in which dcache_stall_i falls in WAIT is a normal (unstalled) cycle, with the load-use and flush rules applied.
REQ-027 Watchdog counter: increments each cycle pipe_stall_o = 1; clears on any cycle pipe_stall_o = 0; saturates at TIMEOUT.
REQ-028 timeout_o is set on the edge at which the watchdog counter reaches TIMEOUT, and stays set until reset.
REQ-029 Performance counters wrap modulo 2^CNT_W:
- mem_stall_cnt_o +1 per cycle with pipe_stall_o = 1.
- lu_bubble_cnt_o +1 per cycle with ID_EX_bubble_o = 1.
- flush_cnt_o +1 per cycle with IF_ID_flush_o = 1.

Reset
REQ-030 rst_i = 1 at a rising edge: state = RUN, watchdog counter = 0, timeout_o = 0, all performance counters = 0; this applies from any state, including mid-WAIT.
REQ-031 While rst_i = 1, the combinational outputs are forced to: PC_write_o = 1, IF_ID_write_o = 1, ID_EX_bubble_o = 0, IF_ID_flush_o = 0, pipe_stall_o = 0.

Configuration
REQ-032 Macro STALL_PERF_EN.
- Defined: the three performance counters are implemented per REQ-029.
- Undefined: no counter flops are implemented, and the three counter ports are tied to 0.
- All other behaviour is identical in both builds.

Verification
REQ-033 EX_MemRead_i = 1, EX_rd_i = 5, ID_rs1_i = 5 for 1 cycle -> ID_EX_bubble_o = 1, PC_write_o = 0, IF_ID_write_o = 0 that cycle; lu_bubble_cnt_o = 1 afterwards. Repeat with EX_rd_i = 0 -> no bubble.
REQ-034 MEM_req_i = 1, dcache_stall_i = 1 for 10 cycles, then 0 -> pipe_stall_o high for exactly 10 cycles and low in cycle 11; state returns to RUN; mem_stall_cnt_o = 10.
REQ-035 ID_branch_taken_i = 1 with load_use = 1 -> IF_ID_flush_o = 0, bubble = 1. Next cycle, branch still taken and no hazard -> IF_ID_flush_o = 1, flush_cnt_o = 1.
REQ-036 TIMEOUT = 8, dcache_stall_i held high for 12 cycles -> timeout_o rises at the 8th stall edge and stays 1 after the stall ends; it clears only on rst_i.
REQ-037 rst_i pulsed in cycle 3 of a WAIT sequence -> pipe_stall_o = 0 during reset; state = RUN and all counters = 0 after the edge; a new miss restarts the counts from 0.
REQ-038 Build without STALL_PERF_EN and rerun the REQ-034 stimulus -> all counter ports = 0, and stall and flush behaviour is unchanged.
